// File: rtl/vadd_seq_if.sv
// Vector-add sequencer bus.
// master: drives start/len/abort and observes addresses, enables and status.
// slave : the sequencer; receives start/len/abort and drives everything else.
//   start   - one-cycle request to begin an operation
//   len     - element count, 0..2^ADDR_W
//   abort   - cancel the running operation
//   rd_addr - read address to source BRAMs A and B
//   rd_en   - read enable to source BRAMs A and B
//   add_en  - clock enable for the adder input register
//   wr_addr - write address to result BRAM C
//   wr_en   - port enable to result BRAM C
//   wea     - write strobe to result BRAM C (same as wr_en)
//   busy    - operation in progress
//   done    - one-cycle completion pulse
//   count   - writes issued in the current operation
interface vadd_seq_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              start;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              add_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              wea;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;

    modport master (
        output start, len, abort,
        input  rd_addr, rd_en, add_en, wr_addr, wr_en, wea, busy, done, count
    );

    modport slave (
        input  start, len, abort,
        output rd_addr, rd_en, add_en, wr_addr, wr_en, wea, busy, done, count
    );
endinterface

// File: rtl/vadd_seq.sv
// Vector-add sequencer: streams indices 0..len-1 to source BRAMs A/B, enables the
// adder register RD_LAT cycles later, and writes each sum to BRAM C at the same
// index RD_LAT+ADD_LAT cycles after its read. Addresses, enables and status only.
// Ports:
//   i_clk  - clock, all logic on posedge
//   i_rst  - synchronous active-high reset
//   io_bus - vadd_seq_if slave modport (start/len/abort in; addr/enables/status out)
module vadd_seq #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    vadd_seq_if.slave  io_bus
);
    localparam int unsigned L = RD_LAT + ADD_LAT;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    state_e                    r_state;
    logic [ADDR_W:0]           r_len;
    logic [ADDR_W:0]           r_count;
    logic [ADDR_W-1:0]         r_rd_addr;
    logic                      r_rd_en;
    logic                      r_busy;
    logic                      r_done;
    // Stage s holds the (valid, addr) of the read issued s cycles ago.
    logic [L:1]                r_vld;
    logic [L:1][ADDR_W-1:0]    r_pa;

    logic                      w_last_rd;
    logic                      w_last_wr;

    // Compare at ADDR_W+1 bits so len = 2^ADDR_W ends at the top address without wrap.
    assign w_last_rd = ({1'b0, r_rd_addr} == (r_len - 1'b1));
    // The write leaving stage L this cycle is the final one of the operation.
    assign w_last_wr = r_vld[L] && ((r_count + 1'b1) == r_len);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_len     <= '0;
            r_count   <= '0;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_vld     <= '0;
            r_pa      <= '0;
        end else begin
            r_vld  <= {r_vld[L-1:1], r_rd_en};
            r_pa   <= {r_pa[L-1:1], r_rd_addr};
            r_done <= 1'b0;
            // A write in the abort cycle still counts; count then holds.
            if (r_vld[L]) begin
                r_count <= r_count + 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_len   <= io_bus.len;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        if (io_bus.len == '0) begin
                            r_state <= StFin;
                        end else begin
                            r_state   <= StRun;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                        end
                    end
                end
                StRun: begin
                    if (io_bus.abort) begin
                        r_state <= StIdle;
                        r_rd_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_vld   <= '0;
                    end else if (w_last_rd) begin
                        r_state <= StDrain;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                StDrain: begin
                    if (io_bus.abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_vld   <= '0;
                    end else if (w_last_wr) begin
                        r_state <= StFin;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                StFin: begin
                    // Entered with done already set after a run; a len=0 run arrives
                    // with done clear and spends one extra cycle here raising it.
                    if (r_done) begin
                        r_state <= StIdle;
                    end else begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign io_bus.rd_addr = r_rd_addr;
    assign io_bus.rd_en   = r_rd_en;
    assign io_bus.add_en  = r_vld[RD_LAT];
    assign io_bus.wr_addr = r_pa[L];
    assign io_bus.wr_en   = r_vld[L];
    assign io_bus.wea     = r_vld[L];
    assign io_bus.busy    = r_busy;
    assign io_bus.done    = r_done;
    assign io_bus.count   = r_count;
endmodule

// File: tb/tb_vadd_seq.sv
// Bench for vadd_seq: two instances (RD_LAT/ADD_LAT = 1/1 and 2/3), a timeline model
// of each operation, per-cycle comparison, directed scenarios and random traffic.
module tb_vadd_seq;
    localparam int AW   = 10;
    localparam int NOAB = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          st[2];
    logic [AW:0]   ln[2];
    logic          ab[2];
    logic          rs[2];

    logic [AW-1:0] o_ra[2];
    logic          o_rd[2];
    logic          o_add[2];
    logic [AW-1:0] o_wa[2];
    logic          o_wr[2];
    logic          o_wea[2];
    logic          o_busy[2];
    logic          o_done[2];
    logic [AW:0]   o_cnt[2];

    vadd_seq_if #(.ADDR_W(AW)) bus0 ();
    vadd_seq_if #(.ADDR_W(AW)) bus1 ();

    vadd_seq #(.ADDR_W(AW), .RD_LAT(1), .ADD_LAT(1)) dut0 (
        .i_clk(clk), .i_rst(rs[0]), .io_bus(bus0.slave)
    );
    vadd_seq #(.ADDR_W(AW), .RD_LAT(2), .ADD_LAT(3)) dut1 (
        .i_clk(clk), .i_rst(rs[1]), .io_bus(bus1.slave)
    );

    assign bus0.start = st[0];
    assign bus0.len   = ln[0];
    assign bus0.abort = ab[0];
    assign bus1.start = st[1];
    assign bus1.len   = ln[1];
    assign bus1.abort = ab[1];

    assign o_ra[0] = bus0.rd_addr;  assign o_ra[1] = bus1.rd_addr;
    assign o_rd[0] = bus0.rd_en;    assign o_rd[1] = bus1.rd_en;
    assign o_add[0] = bus0.add_en;  assign o_add[1] = bus1.add_en;
    assign o_wa[0] = bus0.wr_addr;  assign o_wa[1] = bus1.wr_addr;
    assign o_wr[0] = bus0.wr_en;    assign o_wr[1] = bus1.wr_en;
    assign o_wea[0] = bus0.wea;     assign o_wea[1] = bus1.wea;
    assign o_busy[0] = bus0.busy;   assign o_busy[1] = bus1.busy;
    assign o_done[0] = bus0.done;   assign o_done[1] = bus1.done;
    assign o_cnt[0] = bus0.count;   assign o_cnt[1] = bus1.count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: one record per instance describing the latest accepted operation.
    bit mv[2]  = '{0, 0};
    int mt0[2] = '{0, 0};
    int mn[2]  = '{0, 0};
    int mak[2] = '{NOAB, NOAB};

    int wr_seen[2]   = '{0, 0};
    int done_seen[2] = '{0, 0};
    int last_done[2] = '{-1, -1};
    int wr_cyc_log[2][4096];

    function automatic int rl_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int l_of(input int i);
        return (i == 0) ? 2 : 5;
    endfunction

    function automatic int clampn(input int v, input int n);
        return (v < 0) ? 0 : ((v > n) ? n : v);
    endfunction

    function automatic int done_k(input int i);
        return (mn[i] > 0) ? mn[i] + l_of(i) + 1 : 2;
    endfunction

    function automatic bit m_idle(input int i, input int k);
        if (!mv[i]) return 1'b1;
        if (mak[i] != NOAB) return k >= mak[i] + 1;
        return k >= done_k(i) + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Advance the model on each edge using the inputs the DUT sees at that edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int k;
            k = cyc - mt0[i];
            if (rs[i]) begin
                mv[i] = 1'b0;
            end else if (m_idle(i, k)) begin
                if (st[i]) begin
                    mv[i]  = 1'b1;
                    mt0[i] = cyc;
                    mn[i]  = int'(ln[i]);
                    mak[i] = NOAB;
                end
            end else if (ab[i] && mn[i] > 0 && k >= 1 && k <= mn[i] + l_of(i)) begin
                mak[i] = k;
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int k, n, L, RL;
            int e_rd, e_add, e_wr, e_busy, e_done, e_cnt, e_ra, e_wa;
            bit ra_chk, wa_chk;
            e_rd = 0; e_add = 0; e_wr = 0; e_busy = 0; e_done = 0; e_cnt = 0;
            e_ra = 0; e_wa = 0; ra_chk = 1'b0; wa_chk = 1'b0;
            L  = l_of(i);
            RL = rl_of(i);
            if (!mv[i]) begin
                ra_chk = 1'b1;
                wa_chk = 1'b1;
            end else begin
                k = cyc - mt0[i];
                n = mn[i];
                if (k > mak[i]) begin
                    e_cnt = clampn(mak[i] - L, n);
                end else begin
                    e_rd   = (k >= 1 && k <= n) ? 1 : 0;
                    e_ra   = k - 1;
                    ra_chk = (e_rd != 0);
                    e_add  = (k >= RL + 1 && k <= RL + n) ? 1 : 0;
                    e_wr   = (k >= L + 1 && k <= L + n) ? 1 : 0;
                    e_wa   = k - 1 - L;
                    wa_chk = (e_wr != 0);
                    e_busy = (n > 0) ? ((k >= 1 && k <= n + L) ? 1 : 0) : ((k == 1) ? 1 : 0);
                    e_done = (k == done_k(i)) ? 1 : 0;
                    e_cnt  = clampn(k - 1 - L, n);
                end
            end
            if (cyc > 0) begin
                chk($sformatf("u%0d.rd_en", i), int'(o_rd[i]), e_rd);
                chk($sformatf("u%0d.add_en", i), int'(o_add[i]), e_add);
                chk($sformatf("u%0d.wr_en", i), int'(o_wr[i]), e_wr);
                chk($sformatf("u%0d.wea", i), int'(o_wea[i]), e_wr);
                chk($sformatf("u%0d.busy", i), int'(o_busy[i]), e_busy);
                chk($sformatf("u%0d.done", i), int'(o_done[i]), e_done);
                chk($sformatf("u%0d.count", i), int'(o_cnt[i]), e_cnt);
                if (ra_chk) chk($sformatf("u%0d.rd_addr", i), int'(o_ra[i]), e_ra);
                if (wa_chk) chk($sformatf("u%0d.wr_addr", i), int'(o_wa[i]), e_wa);
            end
            if (o_wr[i] === 1'b1) begin
                wr_cyc_log[i][wr_seen[i] % 4096] = cyc;
                wr_seen[i]++;
            end
            if (o_done[i] === 1'b1) begin
                done_seen[i]++;
                last_done[i] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic go(input int i, input int n, output int s);
        st[i] = 1'b1;
        ln[i] = (AW + 1)'(n);
        s = cyc;
        tick();
        st[i] = 1'b0;
    endtask

    // Bounded wait for the next done pulse; checks its cycle relative to start.
    task automatic wait_done(input int i, input int s, input int budget, input string nm,
                             input int exp_rel);
        int d0;
        d0 = done_seen[i];
        for (int j = 0; j < budget && done_seen[i] == d0; j++) tick();
        chk(nm, (done_seen[i] == d0) ? -1 : last_done[i] - s, exp_rel);
    endtask

    initial begin
        int s, w0, d0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ln[i] = '0; ab[i] = 1'b0; rs[i] = 1'b1;
        end
        tick(); tick(); tick();
        rs[0] = 1'b0;
        rs[1] = 1'b0;
        tick();
        chk("reset.busy", int'(o_busy[0]), 0);
        chk("reset.count", int'(o_cnt[0]), 0);
        chk("reset.rd_addr", int'(o_ra[1]), 0);

        // Nominal len=4.
        w0 = wr_seen[0];
        go(0, 4, s);
        wait_done(0, s, 40, "len4.done_cycle", 7);
        chk("len4.count", int'(o_cnt[0]), 4);
        chk("len4.writes", wr_seen[0] - w0, 4);
        chk("len4.first_wr", wr_cyc_log[0][w0 % 4096] - s, 3);

        // len=0.
        w0 = wr_seen[0];
        go(0, 0, s);
        wait_done(0, s, 20, "len0.done_cycle", 2);
        chk("len0.writes", wr_seen[0] - w0, 0);

        // Full length.
        w0 = wr_seen[0];
        go(0, 1024, s);
        wait_done(0, s, 1100, "full.done_cycle", 1027);
        chk("full.writes", wr_seen[0] - w0, 1024);
        chk("full.count", int'(o_cnt[0]), 1024);
        chk("full.rd_addr_end", int'(o_ra[0]), 1023);

        // start re-pulsed mid-run and in the done cycle.
        w0 = wr_seen[0];
        d0 = done_seen[0];
        go(0, 4, s);
        tick_to(s + 2);
        st[0] = 1'b1; ln[0] = 11'd7;
        tick();
        st[0] = 1'b0;
        tick_to(s + 7);
        st[0] = 1'b1; ln[0] = 11'd7;
        tick();
        st[0] = 1'b0;
        repeat (10) tick();
        chk("restart.writes", wr_seen[0] - w0, 4);
        chk("restart.dones", done_seen[0] - d0, 1);
        chk("restart.count", int'(o_cnt[0]), 4);
        chk("restart.busy", int'(o_busy[0]), 0);
        w0 = wr_seen[0];
        go(0, 7, s);
        wait_done(0, s, 40, "len7.done_cycle", 10);
        chk("len7.writes", wr_seen[0] - w0, 7);

        // Abort at cycle 3 of a len=8 run.
        w0 = wr_seen[0];
        d0 = done_seen[0];
        go(0, 8, s);
        tick_to(s + 3);
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        chk("abort.busy", int'(o_busy[0]), 0);
        chk("abort.wr_en", int'(o_wr[0]), 0);
        repeat (12) tick();
        chk("abort.writes", wr_seen[0] - w0, 1);
        chk("abort.dones", done_seen[0] - d0, 0);
        chk("abort.count", int'(o_cnt[0]), 1);
        w0 = wr_seen[0];
        go(0, 2, s);
        wait_done(0, s, 20, "post_abort.done_cycle", 5);
        chk("post_abort.writes", wr_seen[0] - w0, 2);

        // Longer pipeline: RD_LAT=2, ADD_LAT=3.
        w0 = wr_seen[1];
        go(1, 3, s);
        wait_done(1, s, 30, "lat5.done_cycle", 9);
        chk("lat5.first_wr", wr_cyc_log[1][w0 % 4096] - s, 6);
        chk("lat5.writes", wr_seen[1] - w0, 3);

        // Reset in the middle of a run.
        w0 = wr_seen[1];
        d0 = done_seen[1];
        go(1, 3, s);
        tick_to(s + 4);
        rs[1] = 1'b1;
        tick();
        rs[1] = 1'b0;
        chk("rst.busy", int'(o_busy[1]), 0);
        chk("rst.rd_en", int'(o_rd[1]), 0);
        chk("rst.add_en", int'(o_add[1]), 0);
        chk("rst.count", int'(o_cnt[1]), 0);
        repeat (12) tick();
        chk("rst.writes", wr_seen[1] - w0, 0);
        chk("rst.dones", done_seen[1] - d0, 0);

        // Random traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                rs[i] = ($urandom % 300) == 0;
                st[i] = ($urandom % 6) == 0;
                ab[i] = ($urandom % 40) == 0;
                if (($urandom % 10) == 0) ln[i] = (AW + 1)'($urandom_range(0, 1024));
                else ln[i] = (AW + 1)'($urandom_range(0, 12));
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ab[i] = 1'b0; rs[i] = 1'b0;
        end
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
